// File: rtl/gpia_pkg.sv
// Shared definitions for the GPIA input port: edge-mode encodings, octet
// width, and the per-octet edge-select helper.
package gpia_pkg;

  localparam int OCTET_W = 8;

  localparam logic [1:0] GPIA_EDGE_NONE = 2'b00;
  localparam logic [1:0] GPIA_EDGE_RISE = 2'b01;
  localparam logic [1:0] GPIA_EDGE_FALL = 2'b10;
  localparam logic [1:0] GPIA_EDGE_BOTH = 2'b11;

  // Select which detected transitions count as events for the given mode.
  function automatic logic [OCTET_W-1:0] edge_hit(
    input logic [1:0]         mode,
    input logic [OCTET_W-1:0] rise,
    input logic [OCTET_W-1:0] fall
  );
    case (mode)
      GPIA_EDGE_RISE: edge_hit = rise;
      GPIA_EDGE_FALL: edge_hit = fall;
      GPIA_EDGE_BOTH: edge_hit = rise | fall;
      default:        edge_hit = '0;
    endcase
  endfunction

endpackage

// File: rtl/gpia_input_byte.sv
// One octet of the GPIA input port: pin synchronizer, previous-level
// register, edge detection and eight sticky event flags with
// write-1-to-clear under a single octet strobe.
module gpia_input_byte
  import gpia_pkg::*;
#(
  parameter int SYNC_STAGES = 2
) (
  input  logic               clk_i,
  input  logic               res_i,
  input  logic [OCTET_W-1:0] pins_i,
  input  logic [1:0]         mode_i,
  input  logic               arm_i,
  input  logic [OCTET_W-1:0] d_i,
  input  logic               stb_i,
  input  logic [OCTET_W-1:0] ie_i,
  output logic [OCTET_W-1:0] q_o,
  output logic [OCTET_W-1:0] evt_o,
  output logic               irq_term_o
);

  logic [SYNC_STAGES-1:0][OCTET_W-1:0] sync_q, sync_d;
  logic [OCTET_W-1:0] prev_q, prev_d;
  logic [OCTET_W-1:0] evt_q, evt_d;
  logic [OCTET_W-1:0] rise, fall, hit, clr;

  // Next state: shift the synchronizer, capture previous level, update flags.
  always_comb begin
    // NOTE: every signal gets a default first so no path leaves it unassigned (no latch).
    sync_d    = '0;
    sync_d[0] = pins_i;
    for (int k = 1; k < SYNC_STAGES; k++) begin
      sync_d[k] = sync_q[k-1];
    end
    prev_d = q_o;

    rise = q_o & ~prev_q;
    fall = ~q_o & prev_q;
    // Edges are ignored until the synchronizer and prev hold real pin data.
    hit  = arm_i ? edge_hit(mode_i, rise, fall) : '0;
    clr  = {OCTET_W{stb_i}} & d_i;
    // A new event outranks a simultaneous clear so nothing is lost.
    evt_d = hit | (evt_q & ~clr);
  end

  // State registers with synchronous reset.
  always_ff @(posedge clk_i) begin
    if (res_i) begin
      // NOTE: non-blocking assignments keep every flop sampling pre-edge values.
      sync_q <= '0;
      prev_q <= '0;
      evt_q  <= '0;
    end else begin
      sync_q <= sync_d;
      prev_q <= prev_d;
      evt_q  <= evt_d;
    end
  end

  assign q_o        = sync_q[SYNC_STAGES-1];
  assign evt_o      = evt_q;
  assign irq_term_o = |(evt_q & ie_i);

endmodule

// File: rtl/gpia_input_dword.sv
// GPIA input port top level: WIDTH/8 octet slices, the shared arm counter
// that masks start-up edges, and the registered interrupt output.
// WIDTH must be a multiple of 8; SYNC_STAGES must be in 2..4.
module gpia_input_dword
  import gpia_pkg::*;
#(
  parameter int WIDTH       = 64,
  parameter int SYNC_STAGES = 2
) (
  input  logic                 clk_i,
  input  logic                 res_i,
  input  logic [WIDTH-1:0]     pins_i,
  input  logic [1:0]           mode_i,
  input  logic [WIDTH-1:0]     d_i,
  input  logic [WIDTH/8-1:0]   stb_i,
  input  logic [WIDTH-1:0]     ie_i,
  output logic [WIDTH-1:0]     q_o,
  output logic [WIDTH-1:0]     evt_o,
  output logic                 irq_o
);

  localparam int NOCT    = WIDTH / OCTET_W;
  localparam int ARM_MAX = SYNC_STAGES + 1;
  localparam int ARM_W   = $clog2(SYNC_STAGES + 2);

  logic [ARM_W-1:0] arm_cnt_q, arm_cnt_d;
  logic             arm;
  logic             irq_q, irq_d;
  logic [NOCT-1:0]  irq_terms;

  for (genvar g = 0; g < NOCT; g++) begin : g_octet
    gpia_input_byte #(
      .SYNC_STAGES(SYNC_STAGES)
    ) u_byte (
      .clk_i      (clk_i),
      .res_i      (res_i),
      .pins_i     (pins_i[g*OCTET_W +: OCTET_W]),
      .mode_i     (mode_i),
      .arm_i      (arm),
      .d_i        (d_i[g*OCTET_W +: OCTET_W]),
      .stb_i      (stb_i[g]),
      .ie_i       (ie_i[g*OCTET_W +: OCTET_W]),
      .q_o        (q_o[g*OCTET_W +: OCTET_W]),
      .evt_o      (evt_o[g*OCTET_W +: OCTET_W]),
      .irq_term_o (irq_terms[g])
    );
  end

  // Arm counter saturates once synchronizer and prev are filled; combine irq terms.
  always_comb begin
    arm       = (arm_cnt_q == ARM_W'(ARM_MAX));
    arm_cnt_d = arm ? arm_cnt_q : arm_cnt_q + 1'b1;
    irq_d     = |irq_terms;
  end

  // Arm counter and interrupt registers with synchronous reset.
  always_ff @(posedge clk_i) begin
    if (res_i) begin
      arm_cnt_q <= '0;
      irq_q     <= 1'b0;
    end else begin
      arm_cnt_q <= arm_cnt_d;
      irq_q     <= irq_d;
    end
  end

  assign irq_o = irq_q;

endmodule

// File: tb/tb_gpia_input_dword.sv
// Self-checking bench for gpia_input_dword: directed scenarios followed by
// randomized traffic, with a queue-based scoreboard fed by a reference model.
module tb_gpia_input_dword;

  localparam int WIDTH = 64;
  localparam int SS    = 2;
  localparam int NOCT  = WIDTH / 8;

  logic              clk_i = 1'b0;
  logic              res_i;
  logic [WIDTH-1:0]  pins_i, d_i, ie_i;
  logic [1:0]        mode_i;
  logic [NOCT-1:0]   stb_i;
  logic [WIDTH-1:0]  q_o, evt_o;
  logic              irq_o;

  int n_checks = 0;
  int n_err    = 0;

  typedef struct {
    logic [WIDTH-1:0] q;
    logic [WIDTH-1:0] evt;
    logic             irq;
  } exp_t;

  exp_t sb[$];

  // Reference model state
  logic [WIDTH-1:0] m_hist[$];
  logic [WIDTH-1:0] m_prev, m_evt, m_new_evt, m_cur;
  logic             m_irq, m_new_irq;
  int               m_cyc;
  bit               m_moved, m_wanted, m_cleared;
  exp_t             m_e;

  gpia_input_dword #(
    .WIDTH(WIDTH),
    .SYNC_STAGES(SS)
  ) dut (
    .clk_i  (clk_i),
    .res_i  (res_i),
    .pins_i (pins_i),
    .mode_i (mode_i),
    .d_i    (d_i),
    .stb_i  (stb_i),
    .ie_i   (ie_i),
    .q_o    (q_o),
    .evt_o  (evt_o),
    .irq_o  (irq_o)
  );

  always #5 clk_i = ~clk_i;

  task automatic check(input string name, input logic [WIDTH-1:0] got, input logic [WIDTH-1:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h at %0t", name, got, exp, $time);
    end
  endtask

  task automatic step(input int n);
    repeat (n) @(negedge clk_i);
  endtask

  // Reference model: at every rising edge compute what the outputs become.
  // q is the pin sample taken SS edges earlier; an event fires when the
  // visible level differs from the previous one in a direction the mode
  // selects, provided more than SS non-reset edges have passed.
  initial begin
    repeat (SS) m_hist.push_back('0);
    m_prev = '0; m_evt = '0; m_irq = 1'b0; m_cyc = 0;
    forever begin
      @(posedge clk_i);
      if (res_i) begin
        m_hist.delete();
        repeat (SS) m_hist.push_back('0);
        m_prev = '0; m_evt = '0; m_irq = 1'b0; m_cyc = 0;
      end else begin
        m_cur = m_hist[0];
        for (int i = 0; i < WIDTH; i++) begin
          m_moved   = (m_cur[i] != m_prev[i]);
          m_wanted  = m_cur[i] ? mode_i[0] : mode_i[1];
          m_cleared = stb_i[i/8] && d_i[i];
          m_new_evt[i] = ((m_cyc > SS) && m_moved && m_wanted) || (m_evt[i] && !m_cleared);
        end
        m_new_irq = ((m_evt & ie_i) != '0);
        m_evt  = m_new_evt;
        m_irq  = m_new_irq;
        m_prev = m_cur;
        m_hist.push_back(pins_i);
        void'(m_hist.pop_front());
        if (m_cyc < 1000) m_cyc++;
      end
      m_e.q   = m_hist[0];
      m_e.evt = m_evt;
      m_e.irq = m_irq;
      sb.push_back(m_e);
    end
  end

  // Monitor: each falling edge the DUT presents a new output set; compare.
  initial begin
    exp_t e;
    forever begin
      @(negedge clk_i);
      if (sb.size() == 0) begin
        n_checks++;
        n_err++;
        $display("FAIL scoreboard: got empty queue expected one entry at %0t", $time);
      end else begin
        e = sb.pop_front();
        check("q", q_o, e.q);
        check("evt", evt_o, e.evt);
        check("irq", {63'b0, irq_o}, {63'b0, e.irq});
      end
    end
  end

  // Watchdog so the run always terminates.
  initial begin
    #1_000_000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog expired");
  end

  // Stimulus: directed scenarios, then random traffic.
  initial begin
    res_i  = 1'b1;
    pins_i = '1;
    mode_i = 2'b01;
    d_i    = '0;
    stb_i  = '0;
    ie_i   = '0;

    // 1: reset with pins high; arm suppression keeps evt at zero
    step(1);
    res_i = 1'b0;
    step(5);
    check("t1_q", q_o, '1);
    check("t1_evt", evt_o, '0);
    check("t1_irq", {63'b0, irq_o}, '0);

    // 2: rising edge on bit 5, then irq
    pins_i = '0;
    ie_i   = 64'h20;
    step(4);
    check("t2_evt_quiet", evt_o, '0);
    pins_i[5] = 1'b1;
    step(4);
    check("t2_evt", evt_o, 64'h20);
    check("t2_irq", {63'b0, irq_o}, 64'h1);

    // 3: clear with the wrong octet strobe, then the right one
    d_i   = 64'h20;
    stb_i = 8'h02;
    step(1);
    stb_i = '0;
    check("t3_wrong_stb", evt_o, 64'h20);
    stb_i = 8'h01;
    step(1);
    stb_i = '0;
    check("t3_clear", evt_o, '0);
    step(1);
    check("t3_irq", {63'b0, irq_o}, '0);

    // 4: set/clear collision on bit 40 with mode both
    mode_i = 2'b11;
    d_i    = 64'h1 << 40;
    stb_i  = 8'h20;
    repeat (8) begin
      pins_i[40] = ~pins_i[40];
      step(1);
    end
    check("t4_set_wins", {63'b0, evt_o[40]}, 64'h1);
    step(5);
    check("t4_cleared", {63'b0, evt_o[40]}, '0);
    stb_i = '0;
    d_i   = '0;

    // 5: falling-only mode on bit 63, then mode none with toggling
    mode_i = 2'b10;
    d_i    = '1;
    stb_i  = '1;
    step(1);
    d_i    = '0;
    stb_i  = '0;
    pins_i[63] = 1'b1;
    step(4);
    check("t5_rise_ignored", evt_o, '0);
    pins_i[63] = 1'b0;
    step(4);
    check("t5_fall", evt_o, 64'h8000_0000_0000_0000);
    mode_i = 2'b00;
    repeat (6) begin
      pins_i[7:0] = 8'($urandom);
      pins_i[63]  = ~pins_i[63];
      step(1);
    end
    step(4);
    check("t5_mode_none", evt_o, 64'h8000_0000_0000_0000);

    // 6: reset mid-operation with events and irq pending
    pins_i = '0;
    step(4);
    d_i   = '1;
    stb_i = '1;
    step(1);
    d_i    = '0;
    stb_i  = '0;
    mode_i = 2'b01;
    ie_i   = 64'hFF00;
    pins_i = 64'hFF00;
    step(4);
    check("t6_evt", evt_o, 64'hFF00);
    check("t6_irq", {63'b0, irq_o}, 64'h1);
    res_i = 1'b1;
    step(1);
    res_i = 1'b0;
    check("t6_rst_evt", evt_o, '0);
    check("t6_rst_irq", {63'b0, irq_o}, '0);
    step(6);
    check("t6_rearm_evt", evt_o, '0);
    check("t6_rearm_q", q_o, 64'hFF00);

    // Random traffic
    for (int c = 0; c < 400; c++) begin
      res_i  = ($urandom_range(0, 49) == 0);
      pins_i = pins_i ^ ({$urandom, $urandom} & {$urandom, $urandom});
      mode_i = 2'($urandom_range(0, 3));
      stb_i  = ($urandom_range(0, 3) == 0) ? NOCT'($urandom) : '0;
      d_i    = {$urandom, $urandom};
      ie_i   = {$urandom, $urandom};
      step(1);
    end
    res_i = 1'b0;
    stb_i = '0;
    step(2);

    $display("Result: errors=%0d of %0d checks", n_err, n_checks);
    $finish;
  end

endmodule

// File: doc/gpia_input_dword.md
Name: gpia_input_dword

Overview:
General-purpose input port and the read-side counterpart of the GPIA output register. It synchronizes WIDTH external pins into the clk_i domain and presents their levels to the bus. It detects per-pin edges according to a global mode and latches them into sticky event flags. Software clears the flags octet-by-octet with write-1-to-clear strobes, and the block raises a masked interrupt.

Parameters:
WIDTH, 64, pin count; must be a multiple of 8 (one clear strobe per octet).
SYNC_STAGES, 2, synchronizer flops per pin; legal range 2..4.

Ports:
clk_i  input  1  system clock; all state changes on its rising edge
res_i  input  1  synchronous, active-high reset
pins_i  input  WIDTH  asynchronous external pin levels
mode_i  input  2  edge select: 00 none, 01 rising, 10 falling, 11 both
d_i  input  WIDTH  clear mask; 1 = clear that event flag
stb_i  input  WIDTH/8  per-octet clear strobe; stb_i[k] qualifies d_i[8k+7:8k]
ie_i  input  WIDTH  per-pin interrupt enable
q_o  output  WIDTH  synchronized pin levels
evt_o  output  WIDTH  sticky event flags
irq_o  output  1  registered OR of (evt_o & ie_i)

Behaviour:
- Reset (res_i=1 at a clock edge):
  - synchronizer chain, prev register, evt_o and irq_o all go to 0.
  - arm counter loads 0; q_o=0.
- Reset mid-operation discards pending flags and pipeline contents; the behaviour is the same as reset from idle.
- Synchronizer: pins_i passes through a SYNC_STAGES-deep flop chain. q_o is the last stage. A pin change that meets setup before edge N appears on q_o after edge N+SYNC_STAGES-1.
- prev: one further register holding the previous q_o.
- Edge detect (combinational on q_o/prev):
  - rise = q_o & ~prev
  - fall = ~q_o & prev
  - hit = (mode_i[0] & rise) | (mode_i[1] & fall)
- Arm counter:
  - Width ceil(log2(SYNC_STAGES+2)); counts up from 0 after reset and saturates at SYNC_STAGES+1.
  - While it is below SYNC_STAGES+1, hit is forced to 0.
  - This suppresses spurious edges from pins already high out of reset.
- Event flags, per bit i at each clock edge:
  - clr = stb_i[i/8] & d_i[i]
  - evt_o[i] <= hit[i] | (evt_o[i] & ~clr)
  - Simultaneous set and clear: set wins, so no event is lost.
  - A clear with stb_i low for that octet has no effect.
- Latency: evt_o asserts one edge after q_o shows the transition. irq_o asserts one edge after evt_o.
- irq_o <= |(evt_o & ie_i), registered. Changing ie_i affects irq_o on the next edge.
- mode_i changes take effect immediately on hit. No retroactive events are generated.
- A pin pulse narrower than one clock may be missed. This is not an error.
- Toggling a pin every cycle with mode 11 keeps its flag set continuously; a clear in any such cycle is overridden.

Decomposition:
- Shared package gpia_pkg:
  - mode constants GPIA_EDGE_NONE/RISE/FALL/BOTH (2-bit)
  - localparam for octet width (8)
- Sub-module gpia_input_byte:
  - one octet slice holding the synchronizer, prev, edge detect and 8 event flags, with a single stb_i bit
  - inputs: shared arm-enable and mode
  - outputs: q, evt, and the per-octet irq term
- Top level:
  - instantiates WIDTH/8 slices via generate
  - owns the arm counter and the irq_o register

Test Plan:
1. Reset with pins_i=64'hFFFF_FFFF_FFFF_FFFF, mode 01 -> q_o reaches all-ones after SYNC_STAGES edges; evt_o stays 0 (arm suppression); irq_o=0.
2. After arming, mode 01, pins_i bit 5 goes 0->1 -> q_o[5]=1 after 2 edges, evt_o=64'h20 one edge later. With ie_i[5]=1, irq_o=1 on the following edge.
3. evt_o=64'h20, stb_i=8'h01, d_i=64'h20 -> evt_o=0 next edge, irq_o=0 one edge later. Repeat with stb_i=8'h02 -> evt_o stays 64'h20.
4. Set/clear collision: mode 11, bit 40 toggles so hit lands in the same cycle as stb_i[5]=1, d_i[40]=1 -> evt_o[40] remains 1.
5. Mode 10, bit 63 toggles 0->1->0 -> only the falling edge sets evt_o[63]. Mode 00 with any toggling -> evt_o unchanged.
6. Assert res_i for one cycle while evt_o=64'hFF00 and irq_o=1 -> next edge evt_o=0, irq_o=0. A pin held high then produces no event after re-arm.
